// File: rtl/hex_display_ctrl_if.sv
// hex_display_ctrl_if: Avalon-MM register bus between a CPU master and the hex display slave.
interface hex_display_ctrl_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    modport master (output address, write, writedata, read, input readdata);
    modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: registered 7-segment controller with blank/blink, leading-zero suppression
// and a BCD seconds countdown that raises a sticky DONE interrupt at zero.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hex_display_ctrl_if.slave       bus,
    output logic                    irq,
    output logic [7*NUM_DIGITS-1:0] hex_n
);
    localparam int N    = NUM_DIGITS;
    localparam int W    = 4 * N;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW   = $clog2(CLK_HZ + 1);
    localparam int BW   = $clog2(HALF + 1);
    localparam logic [SW-1:0] SEC_LAST = SW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(HALF - 1);

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    logic [W-1:0]   value_q, value_d, dec;
    logic [N-1:0]   blank_q, blank_d, blink_q, blink_d;
    logic           en_q, en_d, lzs_q, lzs_d, cd_en_q, cd_en_d, done_q, done_d;
    logic [SW-1:0]  sec_cnt_q, sec_cnt_d;
    logic [BW-1:0]  blk_cnt_q, blk_cnt_d;
    logic           off_phase_q, off_phase_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [7*N-1:0] hex_q, hex_d;
    logic           wr_value, wr_blank, wr_blink, wr_ctrl, sec_tick, tick_act, done_set;
    logic           borrow, zero_up, dark;
    logic [3:0]     nib;

    assign wr_value = bus.write && bus.address == 2'd0;
    assign wr_blank = bus.write && bus.address == 2'd1;
    assign wr_blink = bus.write && bus.address == 2'd2;
    assign wr_ctrl  = bus.write && bus.address == 2'd3;
    assign sec_tick = sec_cnt_q == SEC_LAST;
    // A VALUE write on a tick cycle swallows that tick entirely
    assign tick_act = sec_tick && cd_en_q && !wr_value;
    assign done_set = tick_act && (value_q == '0 || dec == '0);

    always_comb begin
        dec = value_q;
        borrow = 1'b1;
        nib = '0;
        for (int k = 0; k < N; k++) begin
            nib = value_q[4*k +: 4];
            dec[4*k +: 4] = !borrow ? nib : (nib == 4'd0) ? 4'd9 : nib - 4'd1;
            borrow = borrow && nib == 4'd0;
        end
    end

    always_comb begin
        value_d     = wr_value ? bus.writedata[W-1:0] : (tick_act && value_q != '0) ? dec : value_q;
        blank_d     = wr_blank ? bus.writedata[N-1:0] : blank_q;
        blink_d     = wr_blink ? bus.writedata[N-1:0] : blink_q;
        en_d        = wr_ctrl ? bus.writedata[0] : en_q;
        lzs_d       = wr_ctrl ? bus.writedata[1] : lzs_q;
        cd_en_d     = done_set ? 1'b0 : wr_ctrl ? bus.writedata[2] : cd_en_q;
        done_d      = done_set || (done_q && !(wr_value || (wr_ctrl && bus.writedata[3])));
        sec_cnt_d   = sec_tick ? '0 : sec_cnt_q + 1'b1;
        blk_cnt_d   = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + 1'b1;
        off_phase_d = off_phase_q ^ (blk_cnt_q == BLK_LAST);
        rdata_d     = !bus.read ? rdata_q :
                      bus.address == 2'd0 ? 32'(value_q) :
                      bus.address == 2'd1 ? 32'(blank_q) :
                      bus.address == 2'd2 ? 32'(blink_q) :
                      {28'd0, done_q, cd_en_q, lzs_q, en_q};
    end

    // Walk from the top digit down so zero_up means "this and every higher nibble is 0"
    always_comb begin
        hex_d = '1;
        zero_up = 1'b1;
        dark = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            zero_up = zero_up && value_q[4*k +: 4] == 4'd0;
            dark = !en_q || blank_q[k] || (blink_q[k] && off_phase_q) || (lzs_q && k > 0 && zero_up);
            hex_d[7*k +: 7] = dark ? 7'h7F : glyph(value_q[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q     <= '0;
            blank_q     <= '0;
            blink_q     <= '0;
            en_q        <= 1'b0;
            lzs_q       <= 1'b0;
            cd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            sec_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            off_phase_q <= 1'b0;
            rdata_q     <= '0;
            hex_q       <= '1;
        end else begin
            value_q     <= value_d;
            blank_q     <= blank_d;
            blink_q     <= blink_d;
            en_q        <= en_d;
            lzs_q       <= lzs_d;
            cd_en_q     <= cd_en_d;
            done_q      <= done_d;
            sec_cnt_q   <= sec_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            off_phase_q <= off_phase_d;
            rdata_q     <= rdata_d;
            hex_q       <= hex_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = done_q;
    assign hex_n        = hex_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed stimulus pushes expected responses to a scoreboard queue;
// a monitor pops and compares whenever a read or display snapshot is presented.
module tb_hex_display_ctrl;
    localparam logic [27:0] ALL_DARK  = 28'hFFFFFFF;
    localparam logic [27:0] H12AF     = {7'h79, 7'h24, 7'h08, 7'h0E};
    localparam logic [27:0] H12AF_D0  = {7'h79, 7'h24, 7'h08, 7'h7F};
    localparam logic [27:0] H0050_LZS = {7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [27:0] H0000_LZS = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] H1000_LZS = {7'h79, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] H0099     = {7'h40, 7'h40, 7'h10, 7'h10};

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        snap = 1'b0;
    logic        irq;
    logic [27:0] hex_n;
    int          cyc;
    int          npass = 0;
    int          ntot = 0;
    ent_t        exp_q[$];

    hex_display_ctrl_if bus ();

    hex_display_ctrl #(.NUM_DIGITS(4), .CLK_HZ(20), .BLINK_HZ(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq), .hex_n(hex_n)
    );

    always #5 clk = ~clk;

    // Mirrors the free-running timebase: posedges since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        ent_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            if (bus.read || snap) begin
                @(negedge clk);
                ntot++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_empty: output presented with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    act = e.kind == 0 ? bus.readdata : e.kind == 1 ? 32'(hex_n) : 32'(irq);
                    if (act === e.exp) npass++;
                    else $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] x, input string n);
        ent_t e;
        e.name = n;
        e.kind = kind;
        e.exp = x;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] x, input string n);
        push(0, x, n);
        bus.address = a;
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [31:0] x, input string n);
        push(kind, x, n);
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    task automatic wait_cyc(input int m);
        @(negedge clk);
        for (int i = 0; i < 40 && cyc % 20 != m; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.address = '0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.read = 1'b0;
        repeat (2) @(negedge clk);
        chk(1, 32'(ALL_DARK), "reset_hex");
        chk(2, 0, "reset_irq");
        rd(0, 0, "reset_readdata");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        wr(0, 32'h12AF);
        chk(1, 32'(ALL_DARK), "hex_before_en");
        wr(3, 32'h1);
        chk(1, 32'(H12AF), "hex_12AF");
        rd(0, 32'h12AF, "rd_value");
        rd(3, 32'h1, "rd_ctrl_en");
        wr(1, 32'hFFFF_FFF0);
        rd(1, 32'h0000_0000, "rd_blank_upper_bits");
        wr(2, 32'hFFFF_FFF5);
        rd(2, 32'h5, "rd_blink_masked");
        wr(2, 32'h0);

        wr(3, 32'h3);
        wr(0, 32'h0050);
        chk(1, 32'(H0050_LZS), "lzs_0050");
        wr(0, 32'h0000);
        chk(1, 32'(H0000_LZS), "lzs_0000");
        wr(0, 32'h1000);
        chk(1, 32'(H1000_LZS), "lzs_1000");

        wr(3, 32'h1);
        wr(0, 32'h12AF);
        wr(2, 32'h1);
        wait_cyc(0);
        for (int i = 0; i < 20; i++)
            chk(1, 32'((cyc % 20 >= 10) ? H12AF_D0 : H12AF), "blink");
        wr(1, 32'h1);
        wait_cyc(2);
        chk(1, 32'(H12AF_D0), "blank_on_phase");
        wait_cyc(12);
        chk(1, 32'(H12AF_D0), "blank_off_phase");
        wr(1, 32'h0);
        wr(2, 32'h0);

        wait_cyc(1);
        wr(0, 32'h0102);
        wr(3, 32'h5);
        wait_cyc(0);
        rd(0, 32'h0101, "cd_0101");
        wait_cyc(0);
        rd(0, 32'h0100, "cd_0100");
        wait_cyc(0);
        rd(0, 32'h0099, "cd_0099");
        chk(1, 32'(H0099), "cd_hex_0099");
        wait_cyc(0);
        rd(0, 32'h0098, "cd_0098");
        wr(0, 32'h0B00);
        wait_cyc(0);
        rd(0, 32'h0A99, "cd_hex_nibble_no_borrow");
        wr(0, 32'h0001);
        wait_cyc(0);
        rd(0, 32'h0000, "cd_reach_zero");
        rd(3, 32'h9, "cd_done_ctrl");
        chk(2, 1, "cd_irq_set");
        wr(3, 32'h9);
        rd(3, 32'h1, "done_cleared_ctrl");
        chk(2, 0, "irq_cleared");

        wr(3, 32'h5);
        wr(0, 32'h0050);
        wait_cyc(19);
        wr(0, 32'h0077);
        rd(0, 32'h0077, "write_wins_over_tick");
        wait_cyc(0);
        rd(0, 32'h0076, "tick_after_write");

        wr(3, 32'h1);
        wr(0, 32'h0020);
        wait_cyc(19);
        wr(3, 32'h5);
        rd(0, 32'h0020, "cd_en_next_tick_only");
        wait_cyc(0);
        rd(0, 32'h0019, "cd_en_took_effect");

        wr(0, 32'h0001);
        wait_cyc(19);
        wr(3, 32'hD);
        rd(3, 32'h9, "done_set_beats_clear");
        chk(2, 1, "irq_set_beats_clear");

        wr(3, 32'h9);
        wr(0, 32'h0042);
        wr(3, 32'h5);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        chk(1, 32'(ALL_DARK), "midcd_reset_hex");
        chk(2, 0, "midcd_reset_irq");
        rd(0, 0, "midcd_reset_readdata");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 0, "post_reset_value");
        rd(3, 0, "post_reset_ctrl");
        repeat (25) @(negedge clk);
        rd(0, 0, "no_resume_value");
        chk(1, 32'(ALL_DARK), "no_resume_hex");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            ntot++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
